// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and helpers for the SPI adapter arbiter
package spi_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } arb_state_t;

    // Address field is never narrower than one bit, even for tiny adapter counts.
    function automatic int addr_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-low reset
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/spi_adapter_arbiter.sv
// rtl/spi_adapter_arbiter.sv - routes one SPI minion push/pull port across several adapters
module spi_adapter_arbiter
    import spi_arb_pkg::*;
#(
    parameter int  nbits        = 8,
    parameter int  num_adapters = 4,
    parameter int  cnt_nbits    = 8,
    localparam int aw           = addr_width(num_adapters),
    localparam int pw           = nbits + aw + 2,
    localparam int aw_pw        = nbits + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_en,
    input  logic [pw-1:0]                 push_msg,
    input  logic                          pull_en,
    output logic [pw-1:0]                 pull_msg,
    output logic [num_adapters-1:0]       adp_push_en,
    output logic [num_adapters*aw_pw-1:0] adp_push_msg,
    output logic [num_adapters-1:0]       adp_pull_en,
    input  logic [num_adapters*aw_pw-1:0] adp_pull_msg,
    output logic [cnt_nbits-1:0]          drop_cnt,
    output logic [cnt_nbits-1:0]          badaddr_cnt,
    output logic                          armed
);

    typedef struct packed {
        logic             val_wrt;
        logic             val_rd;
        logic [aw-1:0]    addr;
        logic [nbits-1:0] data;
    } push_pkt_t;

    typedef struct packed {
        logic             val;
        logic             spc;
        logic [aw-1:0]    addr;
        logic [nbits-1:0] data;
    } pull_pkt_t;

    typedef struct packed {
        logic             val_wrt;
        logic             val_rd;
        logic [nbits-1:0] data;
    } adp_push_t;

    typedef struct packed {
        logic             val;
        logic             spc;
        logic [nbits-1:0] data;
    } adp_pull_t;

    localparam logic [aw:0] num_lim = (aw + 1)'(num_adapters);

    push_pkt_t                    pkt;
    pull_pkt_t                    pull_out;
    adp_push_t [num_adapters-1:0] adp_out;
    adp_pull_t [num_adapters-1:0] adp_in;

    arb_state_t    state, state_d;
    logic [aw-1:0] rd_tgt, spc_tgt;
    logic          addr_ok, push_valid, drop_inc, bad_inc;

    assign pkt          = push_msg;
    assign adp_in       = adp_pull_msg;
    assign adp_push_msg = adp_out;
    assign pull_msg     = pull_out;

    assign addr_ok    = ({1'b0, pkt.addr} < num_lim);
    assign push_valid = push_en & addr_ok;
    assign bad_inc    = push_en & ~addr_ok;
    // A write is lost when the addressed adapter reports no space this cycle.
    assign drop_inc   = push_valid & pkt.val_wrt & ~adp_in[pkt.addr].spc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            rd_tgt  <= '0;
            spc_tgt <= '0;
        end else begin
            state <= state_d;
            if (push_valid && pkt.val_rd) begin
                rd_tgt <= pkt.addr;
            end
            if (push_valid) begin
                spc_tgt <= pkt.addr;
            end
        end
    end

    // A re-arming push outranks the pull that would otherwise return to IDLE.
    always_comb begin
        state_d = state;
        if (push_valid && pkt.val_rd) begin
            state_d = ARMED;
        end else if (state == ARMED && pull_en) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        adp_push_en = '0;
        adp_pull_en = '0;
        adp_out     = '0;
        pull_out    = '0;
        if (push_valid) begin
            adp_push_en[pkt.addr]     = 1'b1;
            adp_out[pkt.addr].val_wrt = pkt.val_wrt;
            adp_out[pkt.addr].data    = pkt.data;
        end
        if (pull_en) begin
            if (state == ARMED) begin
                adp_pull_en[rd_tgt]    = 1'b1;
                adp_out[rd_tgt].val_rd = 1'b1;
                pull_out.val           = adp_in[rd_tgt].val;
                pull_out.spc           = adp_in[rd_tgt].spc;
                pull_out.addr          = rd_tgt;
                pull_out.data          = adp_in[rd_tgt].data;
            end else begin
                pull_out.spc  = adp_in[spc_tgt].spc;
                pull_out.addr = spc_tgt;
            end
        end
    end

    assign armed = (state == ARMED);

    sat_counter #(.width(cnt_nbits)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    sat_counter #(.width(cnt_nbits)) u_badaddr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bad_inc),
        .count (badaddr_cnt)
    );

endmodule

// File: tb/tb_spi_adapter_arbiter.sv
// tb/tb_spi_adapter_arbiter.sv - randomized model-checked bench for spi_adapter_arbiter
module tb_spi_adapter_arbiter;

    localparam int NB  = 8;
    localparam int NA  = 3;
    localparam int CW  = 2;
    localparam int AW  = 2;
    localparam int PW  = NB + AW + 2;
    localparam int APW = NB + 2;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              push_en;
    logic [PW-1:0]     push_msg;
    logic              pull_en;
    logic [PW-1:0]     pull_msg;
    logic [NA-1:0]     adp_push_en;
    logic [NA*APW-1:0] adp_push_msg;
    logic [NA-1:0]     adp_pull_en;
    logic [NA*APW-1:0] adp_pull_msg;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     badaddr_cnt;
    logic              armed;

    bit          p_en = 0, p_wrt = 0, p_rd = 0, l_en = 0;
    logic [1:0]  p_addr = '0;
    logic [7:0]  p_data = '0;
    bit          a_val [NA];
    bit          a_spc [NA];
    logic [7:0]  a_data [NA];

    int checks = 0;
    int failures = 0;
    bit check_en = 0;

    bit m_armed = 0;
    int m_rd = 0, m_spc = 0, m_drop = 0, m_bad = 0;

    always #5 clk = ~clk;

    spi_adapter_arbiter #(.nbits(NB), .num_adapters(NA), .cnt_nbits(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_en      (push_en),
        .push_msg     (push_msg),
        .pull_en      (pull_en),
        .pull_msg     (pull_msg),
        .adp_push_en  (adp_push_en),
        .adp_push_msg (adp_push_msg),
        .adp_pull_en  (adp_pull_en),
        .adp_pull_msg (adp_pull_msg),
        .drop_cnt     (drop_cnt),
        .badaddr_cnt  (badaddr_cnt),
        .armed        (armed)
    );

    assign push_en  = p_en;
    assign push_msg = {p_wrt, p_rd, p_addr, p_data};
    assign pull_en  = l_en;

    always_comb begin
        adp_pull_msg = '0;
        for (int i = 0; i < NA; i++) begin
            adp_pull_msg[i*APW +: APW] = {a_val[i], a_spc[i], a_data[i]};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: outputs follow from inputs plus the abstract arbiter state.
    always @(negedge clk) begin
        if (check_en) begin
            bit                valid;
            logic [NA*APW-1:0] e_msg;
            logic [PW-1:0]     e_pull;
            logic [NA-1:0]     e_pen, e_len;
            valid = p_en && (int'(p_addr) < NA);
            e_pen = valid ? NA'(1 << p_addr) : '0;
            e_len = (l_en && m_armed) ? NA'(1 << m_rd) : '0;
            e_msg = '0;
            for (int i = 0; i < NA; i++) begin
                e_msg[i*APW +: APW] = {(valid && int'(p_addr) == i) ? p_wrt : 1'b0,
                                       (l_en && m_armed && m_rd == i) ? 1'b1 : 1'b0,
                                       (valid && int'(p_addr) == i) ? p_data : 8'h00};
            end
            if (!l_en)        e_pull = '0;
            else if (m_armed) e_pull = {a_val[m_rd], a_spc[m_rd], 2'(m_rd), a_data[m_rd]};
            else              e_pull = {1'b0, a_spc[m_spc], 2'(m_spc), 8'h00};
            chk("adp_push_en", 32'(adp_push_en), 32'(e_pen));
            chk("adp_push_msg", 32'(adp_push_msg), 32'(e_msg));
            chk("adp_pull_en", 32'(adp_pull_en), 32'(e_len));
            chk("pull_msg", 32'(pull_msg), 32'(e_pull));
            chk("armed", 32'(armed), 32'(m_armed));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("badaddr_cnt", 32'(badaddr_cnt), 32'(m_bad));
            if (!reset) begin
                m_armed = 0; m_rd = 0; m_spc = 0; m_drop = 0; m_bad = 0;
            end else begin
                if (valid && p_wrt && !a_spc[p_addr] && m_drop < CMAX) m_drop++;
                if (p_en && !valid && m_bad < CMAX) m_bad++;
                if (valid && p_rd) begin
                    m_armed = 1; m_rd = int'(p_addr);
                end else if (m_armed && l_en) begin
                    m_armed = 0;
                end
                if (valid) m_spc = int'(p_addr);
            end
        end
    end

    task automatic go(input bit pe, input bit wrt, input bit rd, input int addr,
                      input int data, input bit le, input bit rs);
        @(posedge clk);
        #1;
        p_en = pe; p_wrt = wrt; p_rd = rd; p_addr = addr[1:0]; p_data = data[7:0];
        l_en = le; reset = rs;
    endtask

    task automatic idle();
        go(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic set_adp(input int i, input bit v, input bit s, input int d);
        a_val[i] = v; a_spc[i] = s; a_data[i] = d[7:0];
    endtask

    initial begin
        for (int i = 0; i < NA; i++) set_adp(i, 0, 1, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1;
        idle();
        #3;
        chk("reset_armed", 32'(armed), 0);
        chk("reset_pull_msg", 32'(pull_msg), 0);

        // Write routing
        set_adp(2, 0, 1, 0);
        go(1, 1, 0, 2, 'hA5, 0, 1);
        #3;
        chk("t1_push_en", 32'(adp_push_en), 32'b100);
        chk("t1_slice2", 32'(adp_push_msg[2*APW +: APW]), 32'h2A5);
        idle();
        #3;
        chk("t1_drop", 32'(drop_cnt), 0);
        chk("t1_armed", 32'(armed), 0);

        // Armed read
        go(1, 0, 1, 1, 0, 0, 1);
        idle();
        #3;
        chk("t2_armed", 32'(armed), 1);
        set_adp(1, 1, 1, 'h3C);
        go(0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("t2_pull_en", 32'(adp_pull_en), 32'b010);
        chk("t2_pull_msg", 32'(pull_msg), 32'hD3C);
        idle();
        #3;
        chk("t2_disarm", 32'(armed), 0);

        // Idle pull reports space of the last pushed adapter
        go(1, 0, 0, 2, 'h11, 0, 1);
        set_adp(2, 1, 0, 'h99);
        go(0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("t3_pull_msg", 32'(pull_msg), 32'h200);
        chk("t3_pull_en", 32'(adp_pull_en), 0);

        // Drops saturate
        set_adp(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            go(1, 1, 0, 0, k, 0, 1);
            #3;
            chk("t4_drop", 32'(drop_cnt), 32'((k < CMAX) ? k : CMAX));
        end
        idle();
        #3;
        chk("t4_drop_sat", 32'(drop_cnt), 32'(CMAX));

        // Bad address
        go(1, 1, 1, 3, 'h55, 0, 1);
        #3;
        chk("t5_push_en", 32'(adp_push_en), 0);
        idle();
        #3;
        chk("t5_bad", 32'(badaddr_cnt), 1);
        chk("t5_armed", 32'(armed), 0);

        // Simultaneous pull and re-arming push, then reset
        go(1, 0, 1, 0, 0, 0, 1);
        set_adp(0, 1, 0, 'h77);
        go(1, 0, 1, 2, 0, 1, 1);
        #3;
        chk("t6_pull_en", 32'(adp_pull_en), 32'b001);
        chk("t6_pull_msg", 32'(pull_msg), 32'h877);
        chk("t6_push_en", 32'(adp_push_en), 32'b100);
        idle();
        #3;
        chk("t6_rearmed", 32'(armed), 1);
        go(0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("t6_rd_tgt", 32'(adp_pull_en), 32'b100);
        go(1, 0, 1, 1, 0, 0, 1);
        go(0, 0, 0, 0, 0, 0, 0);
        idle();
        #3;
        chk("t6_rst_armed", 32'(armed), 0);
        chk("t6_rst_drop", 32'(drop_cnt), 0);
        chk("t6_rst_bad", 32'(badaddr_cnt), 0);
        set_adp(0, 1, 1, 'hFF);
        go(0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("t6_rst_pull_val", 32'(pull_msg[PW-1]), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NA; i++) begin
                set_adp(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                        int'($urandom_range(0, 255)));
            end
            go(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 149) != 0));
        end
        idle();
        idle();
        @(posedge clk);
        #1;
        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_adapter_arbiter.md
Name: spi_adapter_arbiter

Overview:
- Shares one SPI minion packet interface (push/pull) among num_adapters SPI adapters.
- Each minion packet carries an address field.
- Push packets are routed to the addressed adapter. Read requests arm a target for the next pull.
- Pull responses are returned tagged with the source address. Dropped-write and bad-address events are counted for debug.

Parameters:
- nbits, 8, data width per adapter message
- num_adapters, 4, number of attached adapters (2..16)
- cnt_nbits, 8, width of each saturating error counter

Derived: aw = max(1, clog2(num_adapters)); pw = nbits+aw+2; aw_pw = nbits+2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset; state resets on the rising clk edge where reset==0
- push_en  in  1  minion push strobe
- push_msg  in  pw  {val_wrt, val_rd, addr[aw], data[nbits]}
- pull_en  in  1  minion pull strobe
- pull_msg  out  pw  {val, spc, addr[aw], data[nbits]}
- adp_push_en  out  num_adapters  per-adapter push strobe
- adp_push_msg  out  num_adapters*aw_pw  per-adapter {val_wrt, val_rd, data}; slice i = adapter i
- adp_pull_en  out  num_adapters  per-adapter pull strobe
- adp_pull_msg  in  num_adapters*aw_pw  per-adapter {val, spc, data}
- drop_cnt  out  cnt_nbits  writes lost to a full adapter
- badaddr_cnt  out  cnt_nbits  packets addressed to addr >= num_adapters
- armed  out  1  read target latched

Behaviour:
- Reset values:
  - FSM = IDLE; rd_tgt = 0; spc_tgt = 0.
  - Counters = 0; armed = 0; all adp_* outputs = 0; pull_msg = 0.
- FSM states:
  - IDLE: no read outstanding.
  - ARMED: rd_tgt holds the address to read on the next pull.
- Push handling (combinational routing, registered side effects):
  - push_en=1 with addr < num_adapters:
    - adp_push_en[addr]=1.
    - adp_push_msg[addr] = {val_wrt, 0, data}.
    - All other slices are 0. val_rd is never forwarded on push.
  - Drop: val_wrt=1 and adp_pull_msg[addr].spc==0 in the same cycle → drop_cnt++ (saturating).
  - Push with val_rd=1 → next state ARMED, rd_tgt <= addr. A later val_rd overwrites rd_tgt.
  - spc_tgt <= addr on every valid push.
  - push_en=1 with addr >= num_adapters:
    - No adapter strobed; badaddr_cnt++ (saturating).
    - FSM and rd_tgt unchanged.
- Pull handling (same-cycle response):
  - In ARMED with pull_en=1:
    - adp_pull_en[rd_tgt]=1 and adp_push_msg[rd_tgt].val_rd=1 in the same cycle.
    - pull_msg = {adp val, adp spc, rd_tgt, adp data}.
    - Next state IDLE.
  - In IDLE with pull_en=1:
    - No adapter strobed.
    - pull_msg = {0, adp_pull_msg[spc_tgt].spc, spc_tgt, 0}.
  - pull_en=0: pull_msg = 0.
- Simultaneous push_en and pull_en:
  - Pull uses the pre-edge state (ARMED/rd_tgt).
  - The push may re-arm. When that happens, next state = ARMED with the new address; the push wins over the pull's transition to IDLE.
  - If both target the same adapter, the adp_push_msg slice carries val_wrt from the push and val_rd=1 from the pull.
- Counters saturate at 2^cnt_nbits-1. They are never cleared except by reset.
- armed = (state==ARMED). It is registered, with no combinational path from push_en.
- Reset mid-operation: an armed read is discarded and adapter queue contents are untouched. The first pull after reset returns val=0.

Decomposition:
- Package spi_arb_pkg holds:
  - packed structs for the minion push/pull packets (parameterised by nbits, aw);
  - adapter push/pull message structs;
  - FSM state enum {IDLE, ARMED}.
- One sub-module, sat_counter (width param, inc, output count, synchronous active-low reset), instantiated twice.

Test Plan:
1. Write routing: nbits=8, num_adapters=4; push {wrt=1, rd=0, addr=2, data=0xA5} with adapter 2 spc=1 → adp_push_en=4'b0100, slice2={1,0,0xA5}, drop_cnt=0, armed=0.
2. Read: push {wrt=0, rd=1, addr=1}, next cycle armed=1; pull_en with adapter1 {val=1, spc=1, data=0x3C} → adp_pull_en=4'b0010, pull_msg={1, 1, 1, 0x3C}; armed=0 the cycle after.
3. Idle pull: pull_en with no read armed, last push addr=3, adapter3 spc=0 → pull_msg={0, 0, 3, 0x00}, adp_pull_en=0.
4. Drop and saturation: cnt_nbits=2; five writes to addr 0 with adapter0 spc=0 → drop_cnt 1, 2, 3, 3, 3.
5. Bad address: num_adapters=3; push addr=3 with rd=1 → no adp_push_en, badaddr_cnt=1, armed stays 0.
6. Simultaneous events and reset: armed to addr0; same-cycle pull_en plus push {rd=1, addr=2} → pull served from adapter0, next cycle armed=1 with rd_tgt=2; then reset=0 for 1 cycle → armed=0, counters 0, next pull returns val=0.
